updown_counter: RTL and testbench

UPDOWN_COUNTER -- requirements
Module: updown_counter

---
 rtl/count_pkg.sv | 18 +
 rtl/wrap_tracker.sv | 44 ++++
 rtl/updown_counter.sv | 82 ++++++++
 tb/tb_updown_counter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/count_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | count_pkg : shared defaults, direction codes and types           |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package count_pkg;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_WRAP_W = 8;

  localparam logic MODE_UP   = 1'b1;
  localparam logic MODE_DOWN = 1'b0;

  typedef logic [DEF_WIDTH-1:0]  count_t;
  typedef logic [DEF_WRAP_W-1:0] wrap_t;

endpackage : count_pkg
`default_nettype wire

// File: rtl/wrap_tracker.sv
`default_nettype none
// +------------------------------------------------------------------+
// | wrap_tracker : saturating wrap counter with sticky overflow flag |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module wrap_tracker #(
  parameter int WRAP_W = count_pkg::DEF_WRAP_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wrap_evt,
  input  logic              clr,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              ovf_sticky
);

  localparam logic [WRAP_W-1:0] c_one = {{(WRAP_W-1){1'b0}}, 1'b1};
  localparam logic [WRAP_W-1:0] c_sat = {WRAP_W{1'b1}};

  logic [WRAP_W-1:0] r_wrap_cnt;
  logic              r_ovf;

  // A clear coincident with a wrap counts that wrap as the first one.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrap_cnt <= '0;
      r_ovf      <= 1'b0;
    end else if (clr) begin
      r_wrap_cnt <= wrap_evt ? c_one : '0;
      r_ovf      <= 1'b0;
    end else if (wrap_evt) begin
      if (r_wrap_cnt == c_sat) begin
        r_ovf <= 1'b1;
      end else begin
        r_wrap_cnt <= r_wrap_cnt + c_one;
      end
    end
  end

  assign wrap_cnt   = r_wrap_cnt;
  assign ovf_sticky = r_ovf;

endmodule : wrap_tracker
`default_nettype wire

// File: rtl/updown_counter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | updown_counter : loadable up/down counter with wrap tracking     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module updown_counter
  import count_pkg::*;
#(
  parameter int               WIDTH   = DEF_WIDTH,
  parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}},
  parameter int               WRAP_W  = DEF_WRAP_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              load,
  input  logic              mode,
  input  logic              en,
  input  logic              clr_flags,
  output logic [WIDTH-1:0]  data_out,
  output logic              tc,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              ovf_sticky
);

  localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_count;
  logic             r_tc;

  logic             w_at_top;
  logic             w_at_bot;
  logic             w_wrap_evt;
  logic [WIDTH-1:0] w_load_val;
  logic [WIDTH-1:0] w_next_count;

  assign w_at_top   = (r_count == MAX_VAL);
  assign w_at_bot   = (r_count == '0);
  assign w_load_val = (data_in > MAX_VAL) ? MAX_VAL : data_in;

  // Load takes precedence, so a load on a boundary cycle never counts as a wrap.
  assign w_wrap_evt = !load && en && ((mode == MODE_UP) ? w_at_top : w_at_bot);

  always_comb begin
    w_next_count = r_count;
    if (load) begin
      w_next_count = w_load_val;
    end else if (en) begin
      if (mode == MODE_UP) begin
        w_next_count = w_at_top ? '0 : (r_count + c_one);
      end else begin
        w_next_count = w_at_bot ? MAX_VAL : (r_count - c_one);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
      r_tc    <= 1'b0;
    end else begin
      r_count <= w_next_count;
      r_tc    <= w_wrap_evt;
    end
  end

  wrap_tracker #(
    .WRAP_W (WRAP_W)
  ) u_wrap_tracker (
    .clk        (clk),
    .reset      (reset),
    .wrap_evt   (w_wrap_evt),
    .clr        (clr_flags),
    .wrap_cnt   (wrap_cnt),
    .ovf_sticky (ovf_sticky)
  );

  assign data_out = r_count;
  assign tc       = r_tc;

endmodule : updown_counter
`default_nettype wire

// File: tb/tb_updown_counter.sv
`default_nettype none
// Bench for updown_counter: three instances (default, MAX_VAL=9, WRAP_W=2) share
// one stimulus stream and are checked against an arithmetic model every cycle.
module tb_updown_counter;

  logic        clk;
  logic        reset;
  logic [15:0] data_in;
  logic        load;
  logic        mode;
  logic        en;
  logic        clr_flags;

  logic [15:0] d_out [3];
  logic        t_c   [3];
  logic [7:0]  w_c   [3];
  logic        o_v   [3];
  logic [7:0]  wc_a;
  logic [7:0]  wc_b;
  logic [1:0]  wc_c;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  localparam int MX [3] = '{65535, 9, 65535};
  localparam int WM [3] = '{255, 255, 3};
  string NM [3] = '{"a", "b", "c"};

  int m_cnt [3] = '{0, 0, 0};
  int m_wc  [3] = '{0, 0, 0};
  bit m_tc  [3] = '{1'b0, 1'b0, 1'b0};
  bit m_ovf [3] = '{1'b0, 1'b0, 1'b0};

  updown_counter dut_a (
    .clk(clk), .reset(reset), .data_in(data_in), .load(load), .mode(mode),
    .en(en), .clr_flags(clr_flags), .data_out(d_out[0]), .tc(t_c[0]),
    .wrap_cnt(wc_a), .ovf_sticky(o_v[0])
  );

  updown_counter #(.WIDTH(16), .MAX_VAL(16'd9), .WRAP_W(8)) dut_b (
    .clk(clk), .reset(reset), .data_in(data_in), .load(load), .mode(mode),
    .en(en), .clr_flags(clr_flags), .data_out(d_out[1]), .tc(t_c[1]),
    .wrap_cnt(wc_b), .ovf_sticky(o_v[1])
  );

  updown_counter #(.WIDTH(16), .WRAP_W(2)) dut_c (
    .clk(clk), .reset(reset), .data_in(data_in), .load(load), .mode(mode),
    .en(en), .clr_flags(clr_flags), .data_out(d_out[2]), .tc(t_c[2]),
    .wrap_cnt(wc_c), .ovf_sticky(o_v[2])
  );

  assign w_c[0] = wc_a;
  assign w_c[1] = wc_b;
  assign w_c[2] = {6'b0, wc_c};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: next count from plain integer arithmetic on the sampled controls.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      bit w;
      w = 1'b0;
      if (reset) begin
        m_cnt[k] <= 0;
        m_tc[k]  <= 1'b0;
        m_wc[k]  <= 0;
        m_ovf[k] <= 1'b0;
      end else begin
        if (load) begin
          m_cnt[k] <= (int'(data_in) > MX[k]) ? MX[k] : int'(data_in);
        end else if (en) begin
          if (mode) begin
            w = (m_cnt[k] == MX[k]);
            m_cnt[k] <= w ? 0 : m_cnt[k] + 1;
          end else begin
            w = (m_cnt[k] == 0);
            m_cnt[k] <= w ? MX[k] : m_cnt[k] - 1;
          end
        end
        m_tc[k] <= w;
        if (clr_flags) begin
          m_wc[k]  <= w ? 1 : 0;
          m_ovf[k] <= 1'b0;
        end else if (w) begin
          if (m_wc[k] == WM[k]) m_ovf[k] <= 1'b1;
          else                  m_wc[k]  <= m_wc[k] + 1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        check({"model.", NM[k], ".data_out"}, {16'b0, d_out[k]}, m_cnt[k]);
        check({"model.", NM[k], ".tc"}, {31'b0, t_c[k]}, {31'b0, m_tc[k]});
        check({"model.", NM[k], ".wrap_cnt"}, {24'b0, w_c[k]}, m_wc[k]);
        check({"model.", NM[k], ".ovf_sticky"}, {31'b0, o_v[k]}, {31'b0, m_ovf[k]});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1; load = 1'b0; en = 1'b0; clr_flags = 1'b0; mode = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    logic [15:0] pick [8];
    reset = 1'b1; load = 1'b1; data_in = 16'h1234; mode = 1'b1; en = 1'b1; clr_flags = 1'b1;
    cyc();
    chk_en = 1'b1;
    cyc();
    for (int k = 0; k < 3; k++) begin
      check({"rst.", NM[k], ".data_out"}, {16'b0, d_out[k]}, 32'd0);
      check({"rst.", NM[k], ".tc"}, {31'b0, t_c[k]}, 32'd0);
      check({"rst.", NM[k], ".wrap_cnt"}, {24'b0, w_c[k]}, 32'd0);
      check({"rst.", NM[k], ".ovf"}, {31'b0, o_v[k]}, 32'd0);
    end

    // Up-count through the top boundary
    reset = 1'b0; load = 1'b1; data_in = 16'hFFFE; en = 1'b0; clr_flags = 1'b0;
    cyc();
    check("up.load", {16'b0, d_out[0]}, 32'hFFFE);
    check("up.load_clamp_b", {16'b0, d_out[1]}, 32'd9);
    load = 1'b0; en = 1'b1; mode = 1'b1;
    cyc();
    check("up.c1", {16'b0, d_out[0]}, 32'hFFFF);
    check("up.c1_tc", {31'b0, t_c[0]}, 32'd0);
    cyc();
    check("up.c2", {16'b0, d_out[0]}, 32'h0000);
    check("up.c2_tc", {31'b0, t_c[0]}, 32'd1);
    cyc();
    check("up.c3", {16'b0, d_out[0]}, 32'h0001);
    check("up.c3_tc", {31'b0, t_c[0]}, 32'd0);
    check("up.wrap_cnt", {24'b0, w_c[0]}, 32'd1);

    // Down-count through zero, then hold
    do_reset();
    load = 1'b1; data_in = 16'h0001;
    cyc();
    load = 1'b0; en = 1'b1; mode = 1'b0;
    cyc();
    check("dn.c1", {16'b0, d_out[0]}, 32'h0000);
    check("dn.c1_tc", {31'b0, t_c[0]}, 32'd0);
    cyc();
    check("dn.c2", {16'b0, d_out[0]}, 32'hFFFF);
    check("dn.c2_tc", {31'b0, t_c[0]}, 32'd1);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("hold.data_out", {16'b0, d_out[0]}, 32'hFFFF);
      check("hold.tc", {31'b0, t_c[0]}, 32'd0);
    end

    // Custom MAX_VAL: clamp on load, wrap both ways
    do_reset();
    load = 1'b1; data_in = 16'd15;
    cyc();
    check("mx9.load", {16'b0, d_out[1]}, 32'd9);
    load = 1'b0; en = 1'b1; mode = 1'b1;
    cyc();
    check("mx9.up", {16'b0, d_out[1]}, 32'd0);
    check("mx9.up_tc", {31'b0, t_c[1]}, 32'd1);
    mode = 1'b0;
    cyc();
    check("mx9.dn", {16'b0, d_out[1]}, 32'd9);
    check("mx9.dn_tc", {31'b0, t_c[1]}, 32'd1);
    check("mx9.wrap_cnt", {24'b0, w_c[1]}, 32'd2);

    // Saturation with a 2-bit wrap counter, alternating direction every cycle
    do_reset();
    load = 1'b1; data_in = 16'hFFFF;
    cyc();
    load = 1'b0; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mode = (i % 2 == 0);
      cyc();
    end
    check("sat.wrap_cnt", {24'b0, w_c[2]}, 32'd3);
    check("sat.ovf", {31'b0, o_v[2]}, 32'd1);
    mode = 1'b1; clr_flags = 1'b1;
    cyc();
    check("clrwrap.wrap_cnt", {24'b0, w_c[2]}, 32'd1);
    check("clrwrap.ovf", {31'b0, o_v[2]}, 32'd0);
    check("clrwrap.tc", {31'b0, t_c[2]}, 32'd1);

    // Load on a would-be wrap suppresses it
    clr_flags = 1'b0; mode = 1'b0;
    cyc();
    check("pre_ld.data_out", {16'b0, d_out[0]}, 32'hFFFF);
    check("pre_ld.wrap_cnt", {24'b0, w_c[0]}, 32'd2);
    mode = 1'b1; load = 1'b1; data_in = 16'h0005;
    cyc();
    check("ldwrap.data_out", {16'b0, d_out[0]}, 32'h0005);
    check("ldwrap.tc", {31'b0, t_c[0]}, 32'd0);
    check("ldwrap.wrap_cnt", {24'b0, w_c[0]}, 32'd2);

    // Reset mid-count, resume from zero
    load = 1'b0;
    cyc();
    reset = 1'b1;
    cyc();
    check("midrst.data_out", {16'b0, d_out[0]}, 32'd0);
    reset = 1'b0;
    cyc();
    check("resume.data_out", {16'b0, d_out[0]}, 32'd1);

    // Mixed traffic, checked against the model only
    pick = '{16'h0000, 16'h0001, 16'h0008, 16'h0009, 16'h000A, 16'hFFFE, 16'hFFFF, 16'h7FFF};
    for (int i = 0; i < 400; i++) begin
      reset     = ($urandom_range(0, 59) == 0);
      load      = ($urandom_range(0, 9) == 0);
      en        = ($urandom_range(0, 3) != 0);
      mode      = 1'($urandom_range(0, 1));
      clr_flags = ($urandom_range(0, 24) == 0);
      data_in   = ($urandom_range(0, 3) == 0) ? 16'($urandom) : pick[$urandom_range(0, 7)];
      cyc();
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_updown_counter
`default_nettype wire
